// File: rtl/pc_fetch_unit.sv
// Program counter and fetch sequencer: holds the PC, selects the next PC
// (sequential, branch or jump) and counts retired instructions.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch,
  input  logic        jump,
  input  logic        halt,
  input  logic [15:0] imm16,
  input  logic [25:0] jaddr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_en,
  output logic        halted,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] branch_off;
  logic [31:0] next_pc;

  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  // Jump outranks branch; halt and stall are resolved in the sequential block.
  always_comb begin
    // NOTE: default first so every path assigns next_pc and no latch is inferred.
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[31:28], jaddr, 2'b00};
    end else if (branch) begin
      next_pc = pc_plus4 + branch_off;
    end
  end

  // NOTE: non-blocking assignments so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assert (RESET_PC[1:0] == 2'b00) else $error("RESET_PC is not word aligned");
      state    <= BOOT;
      pc       <= {RESET_PC[31:2], 2'b00};
      fetch_en <= 1'b0;
      halted   <= 1'b0;
      retired  <= 32'd0;
    end else begin
      case (state)
        BOOT: begin
          state    <= RUN;
          fetch_en <= 1'b1;
        end
        RUN: begin
          if (halt) begin
            state    <= HALT;
            fetch_en <= 1'b0;
            halted   <= 1'b1;
            retired  <= retired + 32'd1;
          end else if (!stall) begin
            pc      <= {next_pc[31:2], 2'b00};
            retired <= retired + 32'd1;
          end
        end
        HALT: begin
          // Terminal until reset; everything frozen.
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage for the single-cycle processor. Holds the current PC, presents it to instruction memory and computes the next PC (sequential, branch or jump) from decode outputs. The opcode-match AND chains in the control unit feed its `branch`, `jump` and `halt` inputs. It also keeps a retired-instruction counter for the bench and the debug port.

## Interface
- `RESET_PC`, default 32'h0040_0000: PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hold PC this cycle; no retire.
- `branch`  in  1  conditional branch taken (decode AND zero flag, already combined).
- `jump`  in  1  J-type jump.
- `halt`  in  1  halt opcode decoded for the current instruction.
- `imm16`  in  16  branch offset, in words, signed.
- `jaddr`  in  26  jump target field.
- `pc`  out  32  current PC, registered; drives instruction memory address.
- `pc_plus4`  out  32  pc + 4, combinational.
- `fetch_en`  out  1  instruction-memory read enable, registered.
- `halted`  out  1  high in HALT state.
- `retired`  out  32  count of completed instructions, registered.

## Operation
- FSM states are BOOT, RUN and HALT. Reset enters BOOT.
- BOOT:
  - lasts exactly one cycle after reset release;
  - PC holds RESET_PC, `fetch_en`=0, no retire;
  - always goes to RUN on the next edge.
- RUN:
  - `fetch_en`=1;
  - at each edge, the action is chosen in priority order `halt` > `stall` > `jump` > `branch` > sequential.
  - `halt`=1: PC holds, `retired`+1, go to HALT.
  - `stall`=1: PC and `retired` hold, stay in RUN.
  - `jump`=1: PC ← {pc_plus4[31:28], jaddr, 2'b00}.
  - `branch`=1: PC ← pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00}.
  - Otherwise PC ← pc_plus4.
  - Each of jump, branch and sequential increments `retired` by 1.
- HALT:
  - terminal until reset;
  - `fetch_en`=0, `halted`=1;
  - PC and `retired` frozen;
  - all inputs ignored.
- Arithmetic:
  - all adds are 32-bit modulo 2^32; carry-out is discarded;
  - PC bits [1:0] are always 0. `RESET_PC` must be word aligned; this is checked by a simulation assertion.
- `retired` wraps from 32'hFFFF_FFFF to 0 with no flag.
- `branch` and `jump` both high: jump wins, and the branch offset is ignored.

## Timing
- Reset values: `pc`=RESET_PC, `fetch_en`=0, `halted`=0, `retired`=0, state=BOOT.
- Reset is asynchronous:
  - asserting `rst_n` low mid-operation forces all reset values immediately, without waiting for a clock edge;
  - deassertion is taken on the following rising edge.
- Next-PC latency is one cycle: the selection is made from inputs sampled at edge N and appears on `pc` after edge N.
- `pc_plus4` follows `pc` combinationally with zero cycle latency.
- `fetch_en` is 1 from the first RUN cycle onward. It drops in the same cycle that `halted` rises.
- `halt` has effect only in RUN, including a RUN cycle where `stall` is also high; halt overrides stall.
- Inputs in BOOT and HALT have no effect.

## Test plan
- Reset and BOOT:
  - stimulus: hold `rst_n`=0 for 3 cycles, then release, all controls 0;
  - required: `pc`=0x00400000 with `fetch_en`=0 for 1 cycle;
  - then `pc` takes 0x00400000, 0x00400004, 0x00400008, and `retired` takes 0, 1, 2.
- Branch backward/forward:
  - setup: at `pc`=0x00400010, assert `branch`;
  - `imm16`=16'hFFFC: next `pc`=0x00400004;
  - `imm16`=16'h0003: next `pc`=0x00400020;
  - `branch` with `jump` and `jaddr`=26'h0000100: next `pc`=0x00000400, i.e. jump wins.
- Stall and halt:
  - `stall` for 2 cycles at `pc`=0x00400008: `pc` and `retired` hold;
  - then `halt` together with `stall`: `halted`=1, `fetch_en`=0 and `retired`+1 on the next edge;
  - further `jump` pulses leave `pc` unchanged.
- Wrap-around:
  - setup: `RESET_PC`=32'hFFFF_FFF8, run sequentially;
  - required `pc` sequence: FFFFFFF8, FFFFFFFC, 00000000;
  - force `retired` to FFFFFFFF via a hierarchical deposit, then retire one instruction: `retired`=0.
- Asynchronous reset mid-run:
  - drop `rst_n` between clock edges after 5 instructions;
  - required: `pc`, `retired`, `fetch_en` and `halted` return to reset values before the next edge;
  - the sequence after release matches the first scenario.
